// File: rtl/sp_ram_arbiter.sv
// ---------------------------------------------------------------------------
// sp_ram_arbiter
//
// Purpose:
//   Two-port round-robin arbiter in front of a single-port synchronous SRAM.
//   Each cycle at most one requester is granted, and its access goes straight
//   to the SRAM pins in that same cycle. The SRAM returns read data one cycle
//   later, so the response (rvalidN_o/rdataN_o) follows the grant by exactly
//   one cycle. Throughput is one access per cycle, in any mix of ports.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_i                     port N request (N = 0, 1)
//   addrN_i/weN_i/beN_i/wdataN_i  port N access attributes (don't-care unless granted)
//   gntN_o                     port N granted this cycle (combinational)
//   rvalidN_o                  port N response valid (one cycle after gntN_o)
//   rdataN_o                   port N read data (mem_q_i, valid while rvalidN_o)
//   mem_csn_o/mem_wen_o        SRAM chip select / write enable, active-low
//   mem_a_o/mem_d_o            SRAM address / write data
//   mem_ben_o                  SRAM byte enables, active-low
//   mem_q_i                    SRAM read data, valid one cycle after access
//
// Handshake: a request is accepted in the cycle where reqN_i && gntN_o.
// There is no back-pressure on responses; the requester does not need to
// hold reqN_i after a grant, and a dropped request is simply not served.
// ---------------------------------------------------------------------------
module sp_ram_arbiter #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic                  we0_i,
    input  logic [BE_WIDTH-1:0]   be0_i,
    input  logic [DATA_WIDTH-1:0] wdata0_i,
    output logic                  gnt0_o,
    output logic                  rvalid0_o,
    output logic [DATA_WIDTH-1:0] rdata0_o,

    input  logic                  req1_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic                  we1_i,
    input  logic [BE_WIDTH-1:0]   be1_i,
    input  logic [DATA_WIDTH-1:0] wdata1_i,
    output logic                  gnt1_o,
    output logic                  rvalid1_o,
    output logic [DATA_WIDTH-1:0] rdata1_o,

    output logic                  mem_csn_o,
    output logic                  mem_wen_o,
    output logic [ADDR_WIDTH-1:0] mem_a_o,
    output logic [DATA_WIDTH-1:0] mem_d_o,
    output logic [BE_WIDTH-1:0]   mem_ben_o,
    input  logic [DATA_WIDTH-1:0] mem_q_i
);

    // 1 = port 1 was granted most recently, so port 0 wins the next tie.
    logic last_gnt;
    logic gnt0;
    logic gnt1;
    logic rvalid0_q;
    logic rvalid1_q;

    // Grant decode. Gated with rst_n so nothing reaches the SRAM while the
    // block is held in reset, even though the request inputs may be active.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (req0_i && (!req1_i || last_gnt)) begin
                gnt0 = 1'b1;
            end else if (req1_i) begin
                gnt1 = 1'b1;
            end
        end
    end

    // SRAM pin drive: granted port's access, otherwise a clean idle pattern.
    always_comb begin
        mem_csn_o = 1'b1;
        mem_wen_o = 1'b1;
        mem_a_o   = '0;
        mem_d_o   = '0;
        mem_ben_o = '1;
        if (gnt0) begin
            mem_csn_o = 1'b0;
            mem_wen_o = ~we0_i;
            mem_a_o   = addr0_i;
            mem_d_o   = wdata0_i;
            mem_ben_o = ~be0_i;
        end else if (gnt1) begin
            mem_csn_o = 1'b0;
            mem_wen_o = ~we1_i;
            mem_a_o   = addr1_i;
            mem_d_o   = wdata1_i;
            mem_ben_o = ~be1_i;
        end
    end

    // Priority state only moves on a grant; idle cycles keep it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
        end else if (gnt0) begin
            last_gnt <= 1'b0;
        end else if (gnt1) begin
            last_gnt <= 1'b1;
        end
    end

    // Response tracking: one cycle behind the grant, matching SRAM latency.
    // Reset clears it, so grants issued just before reset never respond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= gnt0;
            rvalid1_q <= gnt1;
        end
    end

    assign gnt0_o    = gnt0;
    assign gnt1_o    = gnt1;
    assign rvalid0_o = rvalid0_q;
    assign rvalid1_o = rvalid1_q;
    assign rdata0_o  = mem_q_i;
    assign rdata1_o  = mem_q_i;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sp_ram_arbiter
//
// Directed bench for sp_ram_arbiter. A behavioural single-port SRAM with
// one-cycle read latency sits on the memory pins. Inputs change on the
// falling edge; outputs are sampled 1 time unit after that edge.
// ---------------------------------------------------------------------------
module tb_sp_ram_arbiter;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk;
    logic          rst_n;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [BW-1:0] be0, be1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_csn, mem_wen;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d;
    logic [BW-1:0] mem_ben;
    logic [DW-1:0] mem_q;

    int total = 0;
    int bad   = 0;

    sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_i(req0), .addr0_i(addr0), .we0_i(we0), .be0_i(be0), .wdata0_i(wdata0),
        .gnt0_o(gnt0), .rvalid0_o(rvalid0), .rdata0_o(rdata0),
        .req1_i(req1), .addr1_i(addr1), .we1_i(we1), .be1_i(be1), .wdata1_i(wdata1),
        .gnt1_o(gnt1), .rvalid1_o(rvalid1), .rdata1_o(rdata1),
        .mem_csn_o(mem_csn), .mem_wen_o(mem_wen), .mem_a_o(mem_a),
        .mem_d_o(mem_d), .mem_ben_o(mem_ben), .mem_q_i(mem_q)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- SRAM model ----------------
    logic [DW-1:0] sram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (!mem_csn) begin
            if (!mem_wen) begin
                for (int b = 0; b < BW; b++)
                    if (!mem_ben[b]) sram[mem_a][8*b +: 8] <= mem_d[8*b +: 8];
            end
            mem_q <= sram[mem_a];
        end
    end

    // ---------------- drivers ----------------
    task automatic drive_idle();
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; be0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; be1 = '0; wdata1 = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 13'h1AB; be0 = 4'hF; wdata0 = 32'hCAFEF00D;
        req1 = 1'b1; we1 = 1'b1; addr1 = 13'h0C3; be1 = 4'hF; wdata1 = 32'h12345678;
        #1;
        if (gnt0 !== 1'b0)     begin bad++; $display("FAIL rst_gnt0 got=%b exp=0", gnt0); end total++;
        if (gnt1 !== 1'b0)     begin bad++; $display("FAIL rst_gnt1 got=%b exp=0", gnt1); end total++;
        if (mem_csn !== 1'b1)  begin bad++; $display("FAIL rst_csn got=%b exp=1", mem_csn); end total++;
        if (mem_wen !== 1'b1)  begin bad++; $display("FAIL rst_wen got=%b exp=1", mem_wen); end total++;
        if (mem_ben !== 4'hF)  begin bad++; $display("FAIL rst_ben got=%h exp=f", mem_ben); end total++;
        if (mem_a !== 13'h0)   begin bad++; $display("FAIL rst_addr got=%h exp=0", mem_a); end total++;
        if (mem_d !== 32'h0)   begin bad++; $display("FAIL rst_data got=%h exp=0", mem_d); end total++;
        @(negedge clk); #1;
        if (rvalid0 !== 1'b0)  begin bad++; $display("FAIL rst_rvalid0 got=%b exp=0", rvalid0); end total++;
        if (rvalid1 !== 1'b0)  begin bad++; $display("FAIL rst_rvalid1 got=%b exp=0", rvalid1); end total++;
    endtask

    // Both ports request from reset release: strict alternation, port 0 first.
    task automatic test_contention();
        logic e_g0, e_g1, e_v0, e_v1;
        @(negedge clk);
        rst_n = 1'b1;
        we0 = 1'b0; we1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            e_g0 = (i % 2 == 0);
            e_g1 = (i % 2 == 1);
            e_v0 = (i > 0) && ((i - 1) % 2 == 0);
            e_v1 = (i > 0) && ((i - 1) % 2 == 1);
            if (gnt0 !== e_g0)    begin bad++; $display("FAIL cont_gnt0[%0d] got=%b exp=%b", i, gnt0, e_g0); end total++;
            if (gnt1 !== e_g1)    begin bad++; $display("FAIL cont_gnt1[%0d] got=%b exp=%b", i, gnt1, e_g1); end total++;
            if (mem_csn !== 1'b0) begin bad++; $display("FAIL cont_csn[%0d] got=%b exp=0", i, mem_csn); end total++;
            if (rvalid0 !== e_v0) begin bad++; $display("FAIL cont_rv0[%0d] got=%b exp=%b", i, rvalid0, e_v0); end total++;
            if (rvalid1 !== e_v1) begin bad++; $display("FAIL cont_rv1[%0d] got=%b exp=%b", i, rvalid1, e_v1); end total++;
            @(negedge clk);
        end
        drive_idle();
        #1;
        if (rvalid1 !== 1'b1) begin bad++; $display("FAIL cont_rv1_tail got=%b exp=1", rvalid1); end total++;
        if (rvalid0 !== 1'b0) begin bad++; $display("FAIL cont_rv0_tail got=%b exp=0", rvalid0); end total++;
        if (mem_csn !== 1'b1) begin bad++; $display("FAIL cont_csn_tail got=%b exp=1", mem_csn); end total++;
    endtask

    task automatic test_single_read();
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 13'h005; be0 = 4'hF; wdata0 = 32'hDEADBEEF;
        addr1 = 13'h077; wdata1 = 32'h55555555; be1 = 4'h3; we1 = 1'b1;
        #1;
        if (gnt0 !== 1'b1)           begin bad++; $display("FAIL sr_wr_gnt0 got=%b exp=1", gnt0); end total++;
        if (gnt1 !== 1'b0)           begin bad++; $display("FAIL sr_wr_gnt1 got=%b exp=0", gnt1); end total++;
        if (mem_csn !== 1'b0)        begin bad++; $display("FAIL sr_wr_csn got=%b exp=0", mem_csn); end total++;
        if (mem_wen !== 1'b0)        begin bad++; $display("FAIL sr_wr_wen got=%b exp=0", mem_wen); end total++;
        if (mem_ben !== 4'h0)        begin bad++; $display("FAIL sr_wr_ben got=%h exp=0", mem_ben); end total++;
        if (mem_a !== 13'h005)       begin bad++; $display("FAIL sr_wr_addr got=%h exp=005", mem_a); end total++;
        if (mem_d !== 32'hDEADBEEF)  begin bad++; $display("FAIL sr_wr_data got=%h exp=deadbeef", mem_d); end total++;
        @(negedge clk);
        we0 = 1'b0; wdata0 = 32'h0;
        #1;
        if (gnt0 !== 1'b1)           begin bad++; $display("FAIL sr_rd_gnt0 got=%b exp=1", gnt0); end total++;
        if (mem_wen !== 1'b1)        begin bad++; $display("FAIL sr_rd_wen got=%b exp=1", mem_wen); end total++;
        if (rvalid0 !== 1'b1)        begin bad++; $display("FAIL sr_wr_rvalid0 got=%b exp=1", rvalid0); end total++;
        if (rvalid1 !== 1'b0)        begin bad++; $display("FAIL sr_wr_rvalid1 got=%b exp=0", rvalid1); end total++;
        @(negedge clk);
        req0 = 1'b0;
        #1;
        if (rvalid0 !== 1'b1)        begin bad++; $display("FAIL sr_rd_rvalid0 got=%b exp=1", rvalid0); end total++;
        if (rdata0 !== 32'hDEADBEEF) begin bad++; $display("FAIL sr_rdata0 got=%h exp=deadbeef", rdata0); end total++;
        if (rvalid1 !== 1'b0)        begin bad++; $display("FAIL sr_rd_rvalid1 got=%b exp=0", rvalid1); end total++;
        if (gnt0 !== 1'b0)           begin bad++; $display("FAIL sr_idle_gnt0 got=%b exp=0", gnt0); end total++;
        @(negedge clk); #1;
        if (rvalid0 !== 1'b0)        begin bad++; $display("FAIL sr_end_rvalid0 got=%b exp=0", rvalid0); end total++;
    endtask

    task automatic test_byte_write();
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = 13'h010; be1 = 4'hF; wdata1 = 32'h0;
        #1;
        if (gnt1 !== 1'b1)           begin bad++; $display("FAIL bw_pre_gnt1 got=%b exp=1", gnt1); end total++;
        @(negedge clk);
        be1 = 4'h4; wdata1 = 32'h11223344;
        #1;
        if (gnt1 !== 1'b1)           begin bad++; $display("FAIL bw_gnt1 got=%b exp=1", gnt1); end total++;
        if (mem_ben !== 4'hB)        begin bad++; $display("FAIL bw_ben got=%h exp=b", mem_ben); end total++;
        if (mem_wen !== 1'b0)        begin bad++; $display("FAIL bw_wen got=%b exp=0", mem_wen); end total++;
        if (mem_a !== 13'h010)       begin bad++; $display("FAIL bw_addr got=%h exp=010", mem_a); end total++;
        if (mem_d !== 32'h11223344)  begin bad++; $display("FAIL bw_data got=%h exp=11223344", mem_d); end total++;
        @(negedge clk);
        we1 = 1'b0; be1 = 4'hF;
        #1;
        if (mem_wen !== 1'b1)        begin bad++; $display("FAIL bw_rd_wen got=%b exp=1", mem_wen); end total++;
        @(negedge clk);
        req1 = 1'b0;
        #1;
        if (rvalid1 !== 1'b1)        begin bad++; $display("FAIL bw_rvalid1 got=%b exp=1", rvalid1); end total++;
        if (rdata1 !== 32'h00220000) begin bad++; $display("FAIL bw_rdata1 got=%h exp=00220000", rdata1); end total++;
        if (rvalid0 !== 1'b0)        begin bad++; $display("FAIL bw_rvalid0 got=%b exp=0", rvalid0); end total++;
    endtask

    // last_gnt is 1 here: a sole port 1 still wins every cycle.
    task automatic test_sole_idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req1 = 1'b1; we1 = 1'b0; addr1 = 13'h020 + 13'(i);
            #1;
            if (gnt1 !== 1'b1) begin bad++; $display("FAIL sole_gnt1[%0d] got=%b exp=1", i, gnt1); end total++;
            if (gnt0 !== 1'b0) begin bad++; $display("FAIL sole_gnt0[%0d] got=%b exp=0", i, gnt0); end total++;
        end
        @(negedge clk);
        req1 = 1'b0; addr1 = 13'h1FF; wdata1 = 32'hA5A5A5A5; be1 = 4'h5; we1 = 1'b1;
        #1;
        if (mem_csn !== 1'b1) begin bad++; $display("FAIL idle_csn got=%b exp=1", mem_csn); end total++;
        if (mem_ben !== 4'hF) begin bad++; $display("FAIL idle_ben got=%h exp=f", mem_ben); end total++;
        if (mem_wen !== 1'b1) begin bad++; $display("FAIL idle_wen got=%b exp=1", mem_wen); end total++;
        if (mem_a !== 13'h0)  begin bad++; $display("FAIL idle_addr got=%h exp=0", mem_a); end total++;
        if (mem_d !== 32'h0)  begin bad++; $display("FAIL idle_data got=%h exp=0", mem_d); end total++;
        if (rvalid1 !== 1'b1) begin bad++; $display("FAIL idle_rv1_last got=%b exp=1", rvalid1); end total++;
        @(negedge clk); #1;
        if (rvalid0 !== 1'b0) begin bad++; $display("FAIL idle_rvalid0 got=%b exp=0", rvalid0); end total++;
        if (rvalid1 !== 1'b0) begin bad++; $display("FAIL idle_rvalid1 got=%b exp=0", rvalid1); end total++;
        if (mem_csn !== 1'b1) begin bad++; $display("FAIL idle_csn2 got=%b exp=1", mem_csn); end total++;
    endtask

    // Port 0 granted twice (last_gnt -> 0), reset lands before the second
    // response; afterwards the first tie must still go to port 0.
    task automatic test_reset_mid_op();
        @(negedge clk);
        drive_idle();
        req0 = 1'b1; addr0 = 13'h005;
        #1;
        if (gnt0 !== 1'b1)    begin bad++; $display("FAIL mid_gnt0_a got=%b exp=1", gnt0); end total++;
        @(negedge clk); #1;
        if (gnt0 !== 1'b1)    begin bad++; $display("FAIL mid_gnt0_k got=%b exp=1", gnt0); end total++;
        #2;
        rst_n = 1'b0;
        req0 = 1'b0;
        #1;
        if (rvalid0 !== 1'b0) begin bad++; $display("FAIL mid_rv0_async got=%b exp=0", rvalid0); end total++;
        @(negedge clk); #1;
        if (rvalid0 !== 1'b0) begin bad++; $display("FAIL mid_rv0_k1 got=%b exp=0", rvalid0); end total++;
        @(negedge clk);
        rst_n = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        #1;
        if (gnt0 !== 1'b1)    begin bad++; $display("FAIL mid_post_gnt0 got=%b exp=1", gnt0); end total++;
        if (gnt1 !== 1'b0)    begin bad++; $display("FAIL mid_post_gnt1 got=%b exp=0", gnt1); end total++;
        if (rvalid0 !== 1'b0) begin bad++; $display("FAIL mid_post_rv0 got=%b exp=0", rvalid0); end total++;
        @(negedge clk); #1;
        if (gnt1 !== 1'b1)    begin bad++; $display("FAIL mid_rr_gnt1 got=%b exp=1", gnt1); end total++;
        if (rvalid0 !== 1'b1) begin bad++; $display("FAIL mid_rr_rv0 got=%b exp=1", rvalid0); end total++;
        drive_idle();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst_n = 1'b0;
        drive_idle();
        test_reset();
        test_contention();
        test_single_read();
        test_byte_write();
        test_sole_idle();
        test_reset_mid_op();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sp_ram_arbiter.md
SP_RAM_ARBITER -- requirements
Module: sp_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 13, SRAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, SRAM word width.
REQ-003 SHALL have parameter BE_WIDTH, default DATA_WIDTH/8, byte-enable width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports reqN_i  input  1  port N (N=0,1) access request.
REQ-007 SHALL have ports addrN_i  input  ADDR_WIDTH  port N word address.
REQ-008 SHALL have ports weN_i  input  1  port N write enable, 1=write.
REQ-009 SHALL have ports beN_i  input  BE_WIDTH  port N byte enables, active-high.
REQ-010 SHALL have ports wdataN_i  input  DATA_WIDTH  port N write data.
REQ-011 SHALL have ports gntN_o  output  1  port N request accepted this cycle.
REQ-012 SHALL have ports rvalidN_o  output  1  port N response valid.
REQ-013 SHALL have ports rdataN_o  output  DATA_WIDTH  port N read data.
REQ-014 SHALL have port mem_csn_o  output  1  SRAM chip select, active-low.
REQ-015 SHALL have port mem_wen_o  output  1  SRAM write enable, active-low.
REQ-016 SHALL have port mem_a_o  output  ADDR_WIDTH  SRAM address.
REQ-017 SHALL have port mem_d_o  output  DATA_WIDTH  SRAM write data.
REQ-018 SHALL have port mem_ben_o  output  BE_WIDTH  SRAM byte enables, active-low.
REQ-019 SHALL have port mem_q_i  input  DATA_WIDTH  SRAM read data, valid one cycle after access.

Function
REQ-020 SHALL grant at most one port per cycle; gntN_o combinational from reqN_i and priority state, same cycle.
REQ-021 SHALL grant a sole requester immediately, whatever the priority state.
REQ-022 SHALL, when both request, grant the port not granted most recently (round-robin); 1-bit last_gnt register.
REQ-023 SHALL update last_gnt only on a grant cycle; no grant leaves it unchanged.
REQ-024 SHALL drive granted port's access to SRAM in grant cycle: mem_csn_o=0, mem_wen_o=~weN_i, mem_ben_o=~beN_i, mem_a_o=addrN_i, mem_d_o=wdataN_i.
REQ-025 SHALL drive idle cycles as mem_csn_o=1, mem_wen_o=1, mem_ben_o=all ones, mem_a_o=0, mem_d_o=0.
REQ-026 SHALL assert rvalidN_o exactly one cycle after every gntN_o cycle, reads and writes alike, for one cycle per grant.
REQ-027 SHALL drive rdataN_o = mem_q_i on both ports; meaningful only while rvalidN_o=1; write-response data undefined.
REQ-028 SHALL support back-to-back grants (one per cycle, any port mix), giving one access per cycle throughput.
REQ-029 SHALL never assert rvalid0_o and rvalid1_o in the same cycle.
REQ-030 SHALL not require a requester to hold reqN_i after grant; a deasserted request is simply not served.
REQ-031 SHALL make addr/we/be/wdata of a non-granted port don't-care.

Reset
REQ-032 SHALL, while rst_n=0, force gnt0_o=gnt1_o=0, rvalid0_o=rvalid1_o=0, mem_csn_o=1, idle SRAM values per REQ-025.
REQ-033 SHALL reset last_gnt to 1, so port 0 wins the first contended cycle.
REQ-034 SHALL drop any pending response on reset assertion; no rvalid after reset release for pre-reset grants.
REQ-035 SHALL grant normally from the first rising clk edge after rst_n deasserts.

Verification
REQ-036 Single read: reset, port 0 writes 0xDEADBEEF to addr 0x005, be=0xF, then reads 0x005 -> gnt0 same cycles, rvalid0 one cycle later, read rdata0_o=0xDEADBEEF, rvalid1 never.
REQ-037 Contention: both req continuously from reset for 6 cycles -> grants 0,1,0,1,0,1; mem_csn_o=0 every cycle; rvalid alternates, delayed one cycle.
REQ-038 Byte write: port 1 writes 0x11223344 be=0x4 to addr 0x010 preloaded 0x00000000 -> mem_ben_o=0xB, mem_wen_o=0; read-back returns 0x00220000.
REQ-039 Idle/sole: only port 1 requests for 3 cycles after last_gnt=1 -> gnt1 every cycle; no requests -> mem_csn_o=1, mem_ben_o=0xF, no rvalid.
REQ-040 Reset mid-op: port 0 granted read in cycle k, rst_n low before edge k+1 -> rvalid0_o stays 0; after release, first contended request goes to port 0.
